// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   op_t     - operation encodings presented on the Op bus
//   state_t  - sequencer states of mult_div_unit
//   DEFAULT_WIDTH - default operand width (HI and LO are each this wide)
package mdu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: unsigned one-bit-per-cycle datapath.
//   Multiply: shift-add, {hiReg,loReg} accumulates the product, loReg holds
//             the multiplier bits still to be consumed.
//   Divide:   restoring division, hiReg is the partial remainder, loReg
//             shifts the dividend out and the quotient in.
// Ports:
//   CLK, Reset      clock, synchronous active-high reset
//   Load            capture operand magnitudes (loadA -> loReg, loadB held)
//   Enable          perform one iteration at the edge
//   IsDiv           1 = divide iteration, 0 = multiply iteration
//   loadA, loadB    multiplier/dividend and multiplicand/divisor magnitudes
//   nextHi, nextLo  register contents after the current iteration
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Enable,
    input  logic             IsDiv,
    input  logic [WIDTH-1:0] loadA,
    input  logic [WIDTH-1:0] loadB,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] bMag;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        // Multiply step: add multiplicand when the current multiplier bit is
        // set, then shift the WIDTH+1-bit sum and loReg right as one unit.
        sum     = {1'b0, hiReg} + (loReg[0] ? {1'b0, bMag} : '0);
        // Divide step: bring the next dividend bit into the remainder and
        // try subtracting the divisor; the borrow bit decides restoration.
        shifted = {hiReg, loReg[WIDTH-1]};
        diff    = shifted - {1'b0, bMag};
        fits    = ~diff[WIDTH];
        if (IsDiv) begin
            nextHi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            nextLo = {loReg[WIDTH-2:0], fits};
        end else begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], loReg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            hiReg <= '0;
            loReg <= '0;
            bMag  <= '0;
        end else if (Load) begin
            hiReg <= '0;
            loReg <= loadA;
            bMag  <= loadB;
        end else if (Enable) begin
            hiReg <= nextHi;
            loReg <= nextLo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional feature macro: MDU_EARLY_OUT_EN (zero multiply operand or zero
// divisor finishes in one cycle instead of WIDTH+1).
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   Start        launch an operation (sampled only in IDLE)
//   Op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busA, busB   rs / rt operands; busA also carries MTHI/MTLO data
//   HiWr, LoWr   MTHI / MTLO strobes (IDLE only, Start has priority)
//   Busy         high while an operation is in flight (RUN or DONE)
//   Done         one-cycle pulse when HI/LO hold the new result
//   HI, LO       high product / remainder, low product / quotient
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             HiWr,
    input  logic             LoWr,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] count;
    op_t              opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;

    logic             startAcc;
    logic             earlyOut;
    logic [WIDTH-1:0] earlyHi;
    logic [WIDTH-1:0] earlyLo;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic             lastIter;

    logic [WIDTH-1:0]   coreHi;
    logic [WIDTH-1:0]   coreLo;
    logic [2*WIDTH-1:0] prod;
    logic               negQuo;
    logic               negRem;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign startAcc = (state == ST_IDLE) && Start;
    assign lastIter = (state == ST_RUN) && (count == CNT_W'(1));

    always_comb begin
        magA = (isSignedOp(Op) && busA[WIDTH-1]) ? '0 - busA : busA;
        magB = (isSignedOp(Op) && busB[WIDTH-1]) ? '0 - busB : busB;
    end

`ifdef MDU_EARLY_OUT_EN
    always_comb begin
        earlyOut = isDivOp(Op) ? (busB == '0) : ((busA == '0) || (busB == '0));
        earlyHi  = isDivOp(Op) ? busA : '0;
        earlyLo  = isDivOp(Op) ? '1   : '0;
    end
`else
    always_comb begin
        earlyOut = 1'b0;
        earlyHi  = '0;
        earlyLo  = '0;
    end
`endif

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) uCore (
        .CLK    (CLK),
        .Reset  (Reset),
        .Load   (startAcc),
        .Enable (state == ST_RUN),
        .IsDiv  (isDivOp(opReg)),
        .loadA  (magA),
        .loadB  (magB),
        .nextHi (coreHi),
        .nextLo (coreLo)
    );

    // The final iteration and the sign fix-up share one edge: the fix-up
    // works on the core's post-iteration values so HI/LO land at DONE entry.
    always_comb begin
        negQuo = isSignedOp(opReg) && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
        negRem = isSignedOp(opReg) && aReg[WIDTH-1];
        prod   = negQuo ? '0 - {coreHi, coreLo} : {coreHi, coreLo};
        fixHi  = prod[2*WIDTH-1:WIDTH];
        fixLo  = prod[WIDTH-1:0];
        if (isDivOp(opReg)) begin
            if (bReg == '0) begin
                fixHi = aReg;
                fixLo = '1;
            end else begin
                fixHi = negRem ? '0 - coreHi : coreHi;
                fixLo = negQuo ? '0 - coreLo : coreLo;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    stateNext = earlyOut ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                Busy = 1'b1;
                if (lastIter) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count <= '0;
            opReg <= OP_MULT;
            aReg  <= '0;
            bReg  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        opReg <= op_t'(Op);
                        aReg  <= busA;
                        bReg  <= busB;
                        if (earlyOut) begin
                            count <= '0;
                            HI    <= earlyHi;
                            LO    <= earlyLo;
                        end else begin
                            count <= CNT_W'(WIDTH);
                        end
                    end else begin
                        if (HiWr) HI <= busA;
                        if (LoWr) LO <= busA;
                    end
                end
                ST_RUN: begin
                    count <= count - CNT_W'(1);
                    if (lastIter) begin
                        HI <= fixHi;
                        LO <= fixLo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        HiWr;
    logic        LoWr;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;
    logic [31:0] mHi;
    logic [31:0] mLo;

    mult_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .busA  (busA),
        .busB  (busB),
        .HiWr  (HiWr),
        .LoWr  (LoWr),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Architectural result of each operation, straight from the arithmetic.
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    function automatic int expLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = 33;
`ifdef MDU_EARLY_OUT_EN
        if ((!op[1] && (a == 32'd0 || b == 32'd0)) || (op[1] && b == 32'd0)) lat = 1;
`endif
        return lat;
    endfunction

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
        logic [31:0] eHi, eLo;
        int          lat;
        bit          busyOk, holdOk;
        refModel(op, a, b, eHi, eLo);
        Op    = op;
        busA  = a;
        busB  = b;
        Start = 1'b1;
        HiWr  = $urandom_range(0, 1);
        LoWr  = $urandom_range(0, 1);
        tick();
        Start  = 1'b0;
        HiWr   = 1'b0;
        LoWr   = 1'b0;
        busA   = $urandom;
        busB   = $urandom;
        lat    = 1;
        busyOk = 1'b1;
        holdOk = 1'b1;
        while (!Done && lat < 100) begin
            if (!Busy) busyOk = 1'b0;
            if (HI !== mHi || LO !== mLo) holdOk = 1'b0;
            if (disturb) begin
                Start = 1'b1;
                HiWr  = 1'b1;
                LoWr  = 1'b1;
                Op    = 2'($urandom);
                busA  = $urandom;
                busB  = $urandom;
            end
            tick();
            lat++;
        end
        Start = 1'b0;
        HiWr  = 1'b0;
        LoWr  = 1'b0;
        checkVal({name, " latency"}, 64'(lat), 64'(expLatency(op, a, b)));
        checkVal({name, " busy/done"}, {62'b0, Busy, Done}, 64'd3);
        checkVal({name, " HI"}, {32'b0, HI}, {32'b0, eHi});
        checkVal({name, " LO"}, {32'b0, LO}, {32'b0, eLo});
        checkVal({name, " busy held"}, {63'b0, busyOk}, 64'd1);
        checkVal({name, " HI/LO held"}, {63'b0, holdOk}, 64'd1);
        mHi = eHi;
        mLo = eLo;
        tick();
        checkVal({name, " idle after"}, {62'b0, Busy, Done}, 64'd0);
    endtask

    task automatic mtWrite(input logic hw, input logic lw, input logic [31:0] d);
        HiWr = hw;
        LoWr = lw;
        busA = d;
        tick();
        HiWr = 1'b0;
        LoWr = 1'b0;
        if (hw) mHi = d;
        if (lw) mLo = d;
        checkVal("mt HI", {32'b0, HI}, {32'b0, mHi});
        checkVal("mt LO", {32'b0, LO}, {32'b0, mLo});
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit sawDone;
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 2'b00;
        busA  = '0;
        busB  = '0;
        HiWr  = 1'b0;
        LoWr  = 1'b0;
        mHi   = '0;
        mLo   = '0;
        tick();
        tick();
        Reset = 1'b0;
        checkVal("reset busy/done", {62'b0, Busy, Done}, 64'd0);
        checkVal("reset HI", {32'b0, HI}, 64'd0);
        checkVal("reset LO", {32'b0, LO}, 64'd0);

        runOp("mult -3*7",      2'b00, 32'hFFFF_FFFD, 32'd7,         1'b0);
        runOp("multu max*max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("div overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp("div -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0);
        runOp("divu 100/7",     2'b11, 32'd100,       32'd7,         1'b0);
        runOp("divu by zero",   2'b11, 32'd100,       32'd0,         1'b0);
        runOp("div -5 by zero", 2'b10, 32'hFFFF_FFFB, 32'd0,         1'b0);
        runOp("mult zero",      2'b00, 32'd0,         32'd12345,     1'b0);

        mtWrite(1'b1, 1'b0, 32'h0000_1234);
        mtWrite(1'b0, 1'b1, 32'hCAFE_0001);
        mtWrite(1'b1, 1'b1, 32'h5A5A_A5A5);

        runOp("mult disturbed", 2'b00, 32'd123456, 32'hFFFF_FF00, 1'b1);
        runOp("div disturbed",  2'b10, 32'hF000_0000, 32'd3,      1'b1);

        for (int i = 0; i < 40; i++) begin
            runOp("random", 2'($urandom_range(0, 3)), pickOperand(), pickOperand(), i[0]);
        end

        // Abort a multiply part way through.
        Op    = 2'b00;
        busA  = 32'd99;
        busB  = 32'd77;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkVal("abort busy/done", {62'b0, Busy, Done}, 64'd0);
        checkVal("abort HI", {32'b0, HI}, 64'd0);
        checkVal("abort LO", {32'b0, LO}, 64'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) sawDone = 1'b1;
            tick();
        end
        checkVal("abort no done", {63'b0, sawDone}, 64'd0);
        mHi = '0;
        mLo = '0;
        runOp("after abort", 2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
